// File: rtl/rockets_pkg.sv
// rockets_pkg: shared rocket geometry, fixed-point format, launch speeds and motion states
package rockets_pkg;
  localparam int FRAC_BITS = 6;
  localparam int SCREEN_TOP = 0;
  localparam int SCREEN_BOTTOM = 479;
  localparam int ROCKET_H = 16;
  localparam int POS_W = 11 + FRAC_BITS;
  localparam logic signed [10:0] PLAYER_FIRE_SPEED = -11'sd128;
  localparam logic signed [10:0] ALIEN_SPEED_0 = 11'sd32;
  localparam logic signed [10:0] ALIEN_SPEED_1 = 11'sd64;
  localparam logic signed [10:0] ALIEN_SPEED_2 = 11'sd128;
  localparam logic signed [10:0] ALIEN_SPEED_3 = 11'sd256;
  typedef enum logic [1:0] {IDLE, FLYING, EXITED} rocket_state_t;
endpackage

// File: rtl/single_rocket_motion_if.sv
// single_rocket_motion_if: controller-side launch bus and per-slot rocket status
interface single_rocket_motion_if;
  logic startOfFrame;
  logic isActive;
  logic signed [10:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic visible;
  logic reachedBorder;
  modport master (
    output startOfFrame, isActive, initialSpeed, initialX, initialY,
    input  topLeftX, topLeftY, visible, reachedBorder
  );
  modport slave (
    input  startOfFrame, isActive, initialSpeed, initialX, initialY,
    output topLeftX, topLeftY, visible, reachedBorder
  );
endinterface

// File: rtl/single_rocket_motion.sv
// single_rocket_motion: latches launch values on isActive rise, then moves the rocket vertically once per frame in fixed point
module single_rocket_motion
  import rockets_pkg::*;
(
  input logic clk,
  input logic resetN,
  single_rocket_motion_if.slave bus
);
  localparam logic signed [POS_W-1:0] Y_MIN = POS_W'(SCREEN_TOP - ROCKET_H);
  localparam logic signed [POS_W-1:0] Y_MAX = POS_W'(SCREEN_BOTTOM);
  rocket_state_t state_q, state_d;
  logic active_dly_q;
  logic rise;
  logic signed [POS_W-1:0] posy_q, posy_d, posy_sum, next_y;
  logic signed [10:0] speed_q, speed_d, x_q, x_d;
  assign rise = bus.isActive & ~active_dly_q;
  assign posy_sum = posy_q + {{FRAC_BITS{speed_q[10]}}, speed_q};
  assign next_y = posy_sum >>> FRAC_BITS;
  // launch latch wins over everything; a fall beats a frame move; border test uses the moved position
  always_comb begin
    state_d = state_q;
    posy_d = posy_q;
    speed_d = speed_q;
    x_d = x_q;
    if (rise) begin
      state_d = FLYING;
      posy_d = {bus.initialY, {FRAC_BITS{1'b0}}};
      speed_d = bus.initialSpeed;
      x_d = bus.initialX;
    end else if (state_q == FLYING) begin
      if (!bus.isActive) state_d = IDLE;
      else if (bus.startOfFrame) begin
        posy_d = posy_sum;
        state_d = (next_y < Y_MIN || next_y > Y_MAX) ? EXITED : FLYING;
      end
    end else if (state_q == EXITED && !bus.isActive) state_d = IDLE;
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      active_dly_q <= 1'b0;
      posy_q <= '0;
      speed_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      active_dly_q <= bus.isActive;
      posy_q <= posy_d;
      speed_q <= speed_d;
      x_q <= x_d;
    end
  end
  assign bus.topLeftX = x_q;
  assign bus.topLeftY = posy_q[POS_W-1:FRAC_BITS];
  assign bus.visible = (state_q == FLYING);
  assign bus.reachedBorder = (state_q == EXITED);
endmodule

// File: tb/tb_single_rocket_motion.sv
// tb_single_rocket_motion: scoreboard-driven check of launch, motion, border exit, fall and reset behaviour
module tb_single_rocket_motion;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;
  single_rocket_motion_if bus();
  single_rocket_motion dut (.clk(clk), .resetN(resetN), .bus(bus));
  typedef struct {
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic vis;
    logic rb;
    bit pos;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  function automatic exp_t mk(int x, int y, bit vis, bit rb, bit pos);
    exp_t r;
    r.x = 11'(x);
    r.y = 11'(y);
    r.vis = vis;
    r.rb = rb;
    r.pos = pos;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(int x, int y, int s);
    bus.initialX = 11'(x);
    bus.initialY = 11'(y);
    bus.initialSpeed = 11'(s);
    bus.isActive = 1'b1;
    tick();
  endtask
  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask
  task automatic fall();
    bus.isActive = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    bus.startOfFrame = 1'b0;
    bus.isActive = 1'b0;
    bus.initialX = '0;
    bus.initialY = '0;
    bus.initialSpeed = '0;
    sb.push_back(mk(0, 0, 0, 0, 1));
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
      failures++;
      $display("FAIL reset: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
    end
    resetN = 1'b1;
    tick();
  endtask
  task automatic test_launch_move();
    sb.push_back(mk(100, 400, 1, 0, 1));
    launch(100, 400, -128);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        sb.push_back(mk(100, 400 - 2 * i, 1, 0, 1));
        frame();
      end
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
        failures++;
        $display("FAIL launch_move[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_half_pixel();
    fall();
    sb.push_back(mk(50, 100, 1, 0, 1));
    launch(50, 100, 32);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        sb.push_back(mk(50, 100 + i - 1, 1, 0, 1));
        frame();
      end
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
        failures++;
        $display("FAIL half_pixel[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_top_exit();
    fall();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin sb.push_back(mk(20, -14, 1, 0, 1)); launch(20, -14, -128); end
        1: begin sb.push_back(mk(20, -16, 1, 0, 1)); frame(); end
        2: begin sb.push_back(mk(0, 0, 0, 1, 0)); frame(); end
        7: begin sb.push_back(mk(0, 0, 0, 0, 0)); fall(); end
        default: begin sb.push_back(mk(0, 0, 0, 1, 0)); tick(); end
      endcase
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || (e.pos && (bus.topLeftX !== e.x || bus.topLeftY !== e.y))) begin
        failures++;
        $display("FAIL top_exit[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_bottom_exit();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin sb.push_back(mk(200, 470, 1, 0, 1)); launch(200, 470, 256); end
        1: begin sb.push_back(mk(200, 474, 1, 0, 1)); frame(); end
        2: begin sb.push_back(mk(200, 478, 1, 0, 1)); frame(); end
        3: begin sb.push_back(mk(0, 0, 0, 1, 0)); frame(); end
        default: begin sb.push_back(mk(0, 0, 0, 0, 0)); fall(); end
      endcase
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || (e.pos && (bus.topLeftX !== e.x || bus.topLeftY !== e.y))) begin
        failures++;
        $display("FAIL bottom_exit[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_fall_with_frame();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sb.push_back(mk(60, 300, 1, 0, 1)); launch(60, 300, -128); end
        1: begin sb.push_back(mk(60, 298, 1, 0, 1)); frame(); end
        default: begin
          sb.push_back(mk(60, 298, 0, 0, 1));
          bus.isActive = 1'b0;
          frame();
        end
      endcase
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
        failures++;
        $display("FAIL fall_with_frame[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_rise_with_frame();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        sb.push_back(mk(70, 200, 1, 0, 1));
        bus.startOfFrame = 1'b1;
        launch(70, 200, -128);
        bus.startOfFrame = 1'b0;
      end else begin
        sb.push_back(mk(70, 198, 1, 0, 1));
        frame();
      end
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
        failures++;
        $display("FAIL rise_with_frame[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_bus_ignore_relaunch();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          bus.initialX = 11'sd300;
          bus.initialY = 11'sd10;
          bus.initialSpeed = 11'sd0;
          sb.push_back(mk(70, 198, 1, 0, 1));
          tick();
        end
        1: begin
          fall();
          sb.push_back(mk(300, 10, 1, 0, 1));
          launch(300, 10, 0);
        end
        default: begin sb.push_back(mk(300, 10, 1, 0, 1)); frame(); end
      endcase
      e = sb.pop_front();
      checks++;
      if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
        failures++;
        $display("FAIL bus_ignore_relaunch[%0d]: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", i, bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
      end
    end
  endtask
  task automatic test_async_reset();
    #3;
    resetN = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 1));
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.visible !== e.vis || bus.reachedBorder !== e.rb || bus.topLeftX !== e.x || bus.topLeftY !== e.y) begin
      failures++;
      $display("FAIL async_reset: got x=%0d y=%0d vis=%b rb=%b want x=%0d y=%0d vis=%b rb=%b", bus.topLeftX, bus.topLeftY, bus.visible, bus.reachedBorder, e.x, e.y, e.vis, e.rb);
    end
    bus.isActive = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_launch_move();
    test_half_pixel();
    test_top_exit();
    test_bottom_exit();
    test_fall_with_frame();
    test_rise_with_frame();
    test_bus_ignore_relaunch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
